// File: rtl/scope_pkg.sv
// Shared widths and default constants for the oscilloscope frame support block.
package scope_pkg;

   localparam int COLOR_W = 12;
   localparam int COORD_W = 8;

   localparam int                 H_PIXELS_DEF     = 160;
   localparam int                 V_PIXELS_DEF     = 120;
   localparam int                 DELAY_CYCLES_DEF = 10008;
   localparam logic [COLOR_W-1:0] CLEAR_COLOR_DEF  = 12'h000;

   // Width of a counter that must hold 0 .. cycles-1; never narrower than one bit.
   function automatic int dly_cnt_w(input int cycles);
      return (cycles <= 2) ? 1 : $clog2(cycles);
   endfunction

endpackage : scope_pkg

// File: rtl/sample_buf_ram.sv
// Simple dual-port sample RAM, single clock, registered read port.
// A read and a write to the same address in one cycle returns the old word.
module sample_buf_ram #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [0:DEPTH-1];
   logic [DATA_W-1:0] rd_data_q;

   // Array write; no reset so the array maps onto block RAM.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Registered read; holds its value while rd_en_i is low.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule : sample_buf_ram

// File: rtl/scope_frame_support.sv
// Display sequencer support: frame-clear pixel sweeper, post-draw delay
// timer and ADC sample buffer. The three engines share only the clock/reset.
module scope_frame_support
   import scope_pkg::*;
#(
   parameter int                 H_PIXELS     = H_PIXELS_DEF,
   parameter int                 V_PIXELS     = V_PIXELS_DEF,
   parameter logic [COLOR_W-1:0] CLEAR_COLOR  = CLEAR_COLOR_DEF,
   parameter int                 DELAY_CYCLES = DELAY_CYCLES_DEF,
   parameter int                 ADDR_W       = 11,
   parameter int                 DATA_W       = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr_enable,
   input  logic               clr_reset,
   output logic [COORD_W-1:0] clr_x,
   output logic [COORD_W-1:0] clr_y,
   output logic [COLOR_W-1:0] clr_color,
   output logic               clr_finished,
   input  logic               dly_enable,
   input  logic               dly_reset,
   output logic               dly_finished,
   input  logic               ram_wr_en,
   input  logic [ADDR_W-1:0]  ram_wr_addr,
   input  logic [DATA_W-1:0]  ram_wr_data,
   input  logic               ram_rd_en,
   input  logic [ADDR_W-1:0]  ram_rd_addr,
   output logic [DATA_W-1:0]  ram_q
);

   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_PIXELS - 1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_PIXELS - 1);

   localparam int                DLY_W    = dly_cnt_w(DELAY_CYCLES);
   localparam logic [DLY_W-1:0]  DLY_LAST = DLY_W'(DELAY_CYCLES - 1);

   // ---------------- clear sweeper ----------------
   logic [COORD_W-1:0] clr_x_q, clr_x_d;
   logic [COORD_W-1:0] clr_y_q, clr_y_d;
   logic               clr_fin_q, clr_fin_d;

   // Next sweep position: restart wins, else raster-advance until the last pixel.
   always_comb begin
      clr_x_d   = clr_x_q;
      clr_y_d   = clr_y_q;
      clr_fin_d = clr_fin_q;
      if (clr_reset) begin
         clr_x_d   = '0;
         clr_y_d   = '0;
         clr_fin_d = 1'b0;
      end else if (clr_enable && !clr_fin_q) begin
         if (clr_x_q != X_LAST) begin
            clr_x_d = clr_x_q + 1'b1;
         end else if (clr_y_q != Y_LAST) begin
            clr_x_d = '0;
            clr_y_d = clr_y_q + 1'b1;
         end else begin
            // Last pixel presented: freeze the coordinates and flag completion.
            clr_fin_d = 1'b1;
         end
      end
   end

   // Sweep state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_x_q   <= '0;
         clr_y_q   <= '0;
         clr_fin_q <= 1'b0;
      end else begin
         clr_x_q   <= clr_x_d;
         clr_y_q   <= clr_y_d;
         clr_fin_q <= clr_fin_d;
      end
   end

   assign clr_x        = clr_x_q;
   assign clr_y        = clr_y_q;
   assign clr_finished = clr_fin_q;
   assign clr_color    = CLEAR_COLOR;

   // ---------------- delay timer ----------------
   logic [DLY_W-1:0] dly_cnt_q, dly_cnt_d;
   logic             dly_fin_q, dly_fin_d;

   // Next timer state: restart wins, else count enabled cycles up to the limit.
   always_comb begin
      dly_cnt_d = dly_cnt_q;
      dly_fin_d = dly_fin_q;
      if (dly_reset) begin
         dly_cnt_d = '0;
         dly_fin_d = 1'b0;
      end else if (dly_enable && !dly_fin_q) begin
         if (dly_cnt_q == DLY_LAST) begin
            dly_fin_d = 1'b1;
         end else begin
            dly_cnt_d = dly_cnt_q + 1'b1;
         end
      end
   end

   // Timer state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dly_cnt_q <= '0;
         dly_fin_q <= 1'b0;
      end else begin
         dly_cnt_q <= dly_cnt_d;
         dly_fin_q <= dly_fin_d;
      end
   end

   assign dly_finished = dly_fin_q;

   // ---------------- sample buffer ----------------
   sample_buf_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_sample_buf_ram (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .wr_en_i   (ram_wr_en),
      .wr_addr_i (ram_wr_addr),
      .wr_data_i (ram_wr_data),
      .rd_en_i   (ram_rd_en),
      .rd_addr_i (ram_rd_addr),
      .rd_data_o (ram_q)
   );

endmodule : scope_frame_support

// File: tb/tb_scope_frame_support.sv
// Bench for scope_frame_support: a default-parameter instance plus one with
// a 4-cycle delay timer; a reference model tracks counts of enabled cycles.
module tb_scope_frame_support;

   localparam int H   = 160;
   localparam int V   = 120;
   localparam int HV  = H * V;
   localparam int DLY = 10008;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        clr_enable = 1'b0, clr_reset = 1'b0;
   logic        dly_enable = 1'b0, dly_reset = 1'b0;
   logic        dly4_enable = 1'b0, dly4_reset = 1'b0;
   logic        ram_wr_en = 1'b0, ram_rd_en = 1'b0;
   logic [10:0] ram_wr_addr = '0, ram_rd_addr = '0;
   logic [7:0]  ram_wr_data = '0;

   logic [7:0]  clr_x, clr_y, clr_x4, clr_y4;
   logic [11:0] clr_color, clr_color4;
   logic        clr_finished, clr_finished4, dly_finished, dly_finished4;
   logic [7:0]  ram_q, ram_q4;

   scope_frame_support u_dut (
      .clk (clk), .rst_n (rst_n),
      .clr_enable (clr_enable), .clr_reset (clr_reset),
      .clr_x (clr_x), .clr_y (clr_y), .clr_color (clr_color), .clr_finished (clr_finished),
      .dly_enable (dly_enable), .dly_reset (dly_reset), .dly_finished (dly_finished),
      .ram_wr_en (ram_wr_en), .ram_wr_addr (ram_wr_addr), .ram_wr_data (ram_wr_data),
      .ram_rd_en (ram_rd_en), .ram_rd_addr (ram_rd_addr), .ram_q (ram_q)
   );

   scope_frame_support #(.DELAY_CYCLES (4)) u_dut4 (
      .clk (clk), .rst_n (rst_n),
      .clr_enable (clr_enable), .clr_reset (clr_reset),
      .clr_x (clr_x4), .clr_y (clr_y4), .clr_color (clr_color4), .clr_finished (clr_finished4),
      .dly_enable (dly4_enable), .dly_reset (dly4_reset), .dly_finished (dly_finished4),
      .ram_wr_en (ram_wr_en), .ram_wr_addr (ram_wr_addr), .ram_wr_data (ram_wr_data),
      .ram_rd_en (ram_rd_en), .ram_rd_addr (ram_rd_addr), .ram_q (ram_q4)
   );

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // The clear engine is modelled as a count of enabled cycles since restart,
   // saturating at H*V; the timers likewise; the RAM as a plain array.
   int         m_clr_n  = 0;
   int         m_dly_n  = 0;
   int         m_dly4_n = 0;
   logic [7:0] m_mem   [0:2047];
   bit         m_valid [0:2047];
   logic [7:0] m_q       = '0;
   bit         m_q_known = 1'b1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_clr_n   = 0;
         m_dly_n   = 0;
         m_dly4_n  = 0;
         m_q       = '0;
         m_q_known = 1'b1;
      end else begin
         if (clr_reset) m_clr_n = 0;
         else if (clr_enable && m_clr_n < HV) m_clr_n++;
         if (dly_reset) m_dly_n = 0;
         else if (dly_enable && m_dly_n < DLY) m_dly_n++;
         if (dly4_reset) m_dly4_n = 0;
         else if (dly4_enable && m_dly4_n < 4) m_dly4_n++;
         if (ram_rd_en) begin
            m_q       = m_mem[ram_rd_addr];
            m_q_known = m_valid[ram_rd_addr];
         end
         if (ram_wr_en) begin
            m_mem[ram_wr_addr]   = ram_wr_data;
            m_valid[ram_wr_addr] = 1'b1;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (check_en) begin
         int idx;
         idx = (m_clr_n >= HV) ? HV - 1 : m_clr_n;
         chk("clr_x",       clr_x,         idx % H);
         chk("clr_y",       clr_y,         idx / H);
         chk("clr_fin",     clr_finished,  m_clr_n >= HV);
         chk("clr_color",   clr_color,     12'h000);
         chk("clr_x4",      clr_x4,        idx % H);
         chk("clr_y4",      clr_y4,        idx / H);
         chk("clr_fin4",    clr_finished4, m_clr_n >= HV);
         chk("dly_fin",     dly_finished,  m_dly_n >= DLY);
         chk("dly4_fin",    dly_finished4, m_dly4_n >= 4);
         if (m_q_known) begin
            chk("ram_q",  ram_q,  m_q);
            chk("ram_q4", ram_q4, m_q);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ram_write(input logic [10:0] a, input logic [7:0] d);
      ram_wr_en = 1'b1; ram_wr_addr = a; ram_wr_data = d;
      step();
      ram_wr_en = 1'b0;
   endtask

   task automatic ram_read(input logic [10:0] a);
      ram_rd_en = 1'b1; ram_rd_addr = a;
      step();
      ram_rd_en = 1'b0;
   endtask

   task automatic clear_restart();
      clr_enable = 1'b0; clr_reset = 1'b1;
      step();
      clr_reset = 1'b0;
   endtask

   // Runs the sweep with enable held until finished; returns enabled edges seen.
   task automatic sweep_to_end(output int cnt);
      cnt = 0;
      clr_enable = 1'b1;
      while (!clr_finished && cnt < HV + 100) begin
         step();
         cnt++;
      end
   endtask

   // ---------------- directed sequence ----------------
   bit en_pat [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      int cnt;
      bit seen_wrap;
      repeat (3) step();
      check_en = 1'b1;
      chk("rst_clr_x", clr_x, 0);
      chk("rst_clr_y", clr_y, 0);
      chk("rst_clr_fin", clr_finished, 0);
      chk("rst_dly_fin", dly_finished, 0);
      chk("rst_ram_q", ram_q, 0);
      rst_n = 1'b1;
      step();

      // Give ram_q a nonzero value so the async reset visibly clears it.
      ram_write(11'd5, 8'h3C);
      ram_read(11'd5);
      chk("ram_pre", ram_q, 8'h3C);

      // Reset mid-sweep, asserted between clock edges.
      clear_restart();
      clr_enable = 1'b1;
      repeat (500) step();
      chk("mid_x", clr_x, 20);
      chk("mid_y", clr_y, 3);
      #2 rst_n = 1'b0;
      #1;
      chk("async_x", clr_x, 0);
      chk("async_y", clr_y, 0);
      chk("async_fin", clr_finished, 0);
      chk("async_q", ram_q, 0);
      clr_enable = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();

      // Full sweep with wrap and end checks.
      clear_restart();
      chk("first_xy", {clr_y, clr_x}, {8'd0, 8'd0});
      clr_enable = 1'b1;
      cnt = 0;
      seen_wrap = 1'b0;
      while (!clr_finished && cnt < HV + 100) begin
         step();
         cnt++;
         if (!seen_wrap && clr_x == 8'd159 && clr_y == 8'd0) begin
            seen_wrap = 1'b1;
            step();
            cnt++;
            chk("wrap_xy", {clr_y, clr_x}, {8'd1, 8'd0});
         end
      end
      chk("sweep_cycles", cnt, 19200);
      chk("last_x", clr_x, 159);
      chk("last_y", clr_y, 119);
      repeat (5) step();
      chk("frozen_x", clr_x, 159);
      chk("frozen_fin", clr_finished, 1);
      chk("color", clr_color, 12'h000);

      // Pause at (10,3), resume, then reset together with enable.
      clear_restart();
      clr_enable = 1'b1;
      repeat (490) step();
      clr_enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("pause_xy", {clr_y, clr_x}, {8'd3, 8'd10});
         step();
      end
      sweep_to_end(cnt);
      chk("resume_cycles", cnt, 19200 - 490);
      clr_reset = 1'b1; clr_enable = 1'b1;
      step();
      chk("rst_wins_xy", {clr_y, clr_x}, {8'd0, 8'd0});
      chk("rst_wins_fin", clr_finished, 0);
      clr_reset = 1'b0; clr_enable = 1'b0;
      step();

      // Default delay timer.
      dly_reset = 1'b1; dly4_reset = 1'b1;
      step();
      dly_reset = 1'b0; dly4_reset = 1'b0;
      dly_enable = 1'b1;
      cnt = 0;
      while (!dly_finished && cnt < DLY + 100) begin
         step();
         cnt++;
      end
      chk("dly_cycles", cnt, 10008);
      dly_enable = 1'b0;

      // Four-cycle timer with a two-cycle gap.
      for (int i = 0; i < 6; i++) begin
         dly4_enable = en_pat[i];
         step();
         if (i == 4) chk("dly4_early", dly_finished4, 0);
      end
      dly4_enable = 1'b0;
      chk("dly4_done", dly_finished4, 1);
      step();
      chk("dly4_sticky", dly_finished4, 1);
      dly_reset = 1'b1; dly4_reset = 1'b1;
      step();
      dly_reset = 1'b0; dly4_reset = 1'b0;
      chk("dly_cleared", dly_finished, 0);
      chk("dly4_cleared", dly_finished4, 0);

      // RAM boundary addresses and hold.
      ram_write(11'd0, 8'h5A);
      ram_write(11'd2047, 8'hA5);
      ram_read(11'd0);
      chk("rd_addr0", ram_q, 8'h5A);
      ram_read(11'd2047);
      chk("rd_addr2047", ram_q, 8'hA5);
      ram_rd_addr = 11'd0;
      step();
      chk("rd_hold", ram_q, 8'hA5);

      // Same-address read/write collision returns the old word.
      ram_write(11'd7, 8'h11);
      ram_wr_en = 1'b1; ram_wr_addr = 11'd7; ram_wr_data = 8'h22;
      ram_rd_en = 1'b1; ram_rd_addr = 11'd7;
      step();
      ram_wr_en = 1'b0; ram_rd_en = 1'b0;
      chk("collide_old", ram_q, 8'h11);
      ram_read(11'd7);
      chk("collide_new", ram_q, 8'h22);
      step();

      check_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_scope_frame_support
